// File: rtl/zfetch.sv
// zfetch: depth-read stage ahead of z-test. Buffers incoming fragments, fetches each
// pixel's stored depth over an Avalon-MM read master and emits fragment + old depth in order.
module zfetch #(
    parameter int IN_LOG2      = 3,
    parameter int OUT_LOG2     = 3,
    parameter int DEPTH_OFFSET = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        input_valid,
    input  logic [25:0] addr_in,
    input  logic [31:0] color_in,
    input  logic [31:0] new_depth_in,
    input  logic        done_in,
    output logic        stall_out,
    output logic        output_valid,
    output logic [25:0] addr_out,
    output logic [31:0] color_out,
    output logic [31:0] new_depth_out,
    output logic [31:0] old_depth_out,
    output logic        done_out,
    input  logic        stall_in,
    output logic [25:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [3:0]  master_byteenable,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    input  logic        master_waitrequest,
    output logic        debug_state
);
    localparam int IN_DEPTH  = 1 << IN_LOG2;
    localparam int IN_HIGH_I = IN_DEPTH - 2;
    localparam int OUT_DEPTH = 1 << OUT_LOG2;

    localparam logic [IN_LOG2:0]  IN_FULL  = IN_DEPTH[IN_LOG2:0];
    localparam logic [IN_LOG2:0]  IN_HIGH  = IN_HIGH_I[IN_LOG2:0];
    localparam logic [IN_LOG2:0]  IN_ONE   = {{IN_LOG2{1'b0}}, 1'b1};
    localparam logic [OUT_LOG2:0] OUT_FULL = OUT_DEPTH[OUT_LOG2:0];
    localparam logic [OUT_LOG2:0] OUT_ONE  = {{OUT_LOG2{1'b0}}, 1'b1};
    localparam logic [25:0]       OFFSET   = DEPTH_OFFSET[25:0];

    typedef struct packed {
        logic [25:0] addr;
        logic [31:0] color;
        logic [31:0] depth;
        logic        done;
    } frag_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t state, state_next;

    // Input fragment FIFO (pointers carry one extra wrap bit)
    frag_t              in_mem [IN_DEPTH];
    logic [IN_LOG2:0]   in_wr, in_rd, in_count, in_count_next;
    logic               in_push, in_pop, in_empty, in_full;
    frag_t              frag_in, in_head;

    // Metadata FIFO: one entry per accepted read, so its occupancy is the outstanding count
    frag_t              meta_mem [OUT_DEPTH];
    logic [OUT_LOG2:0]  meta_wr, meta_rd, outstanding, outstanding_next;
    frag_t              meta_head;

    logic [31:0]        resp_mem [OUT_DEPTH];
    logic [OUT_LOG2:0]  resp_wr, resp_rd, resp_count;
    logic               resp_push;

    frag_t              issue;
    logic               load, accept, out_pop;

    assign frag_in   = '{addr: addr_in, color: color_in, depth: new_depth_in, done: done_in};
    assign in_count  = in_wr - in_rd;
    assign in_empty  = (in_count == '0);
    assign in_full   = (in_count == IN_FULL);
    assign in_push   = input_valid && !in_full;
    assign in_pop    = load;
    assign in_head   = in_mem[in_rd[IN_LOG2-1:0]];
    assign in_count_next = in_count + {{IN_LOG2{1'b0}}, in_push} - {{IN_LOG2{1'b0}}, in_pop};

    assign outstanding = meta_wr - meta_rd;
    assign resp_count  = resp_wr - resp_rd;
    assign meta_head   = meta_mem[meta_rd[OUT_LOG2-1:0]];

    assign master_read       = (state == S_REQ);
    assign master_write      = 1'b0;
    assign master_byteenable = 4'b1111;
    assign debug_state       = (state == S_REQ);
    assign accept            = master_read && !master_waitrequest;

    // Responses beyond the number of reads we own (e.g. leftovers from before reset) are dropped.
    assign resp_push = master_readdatavalid && (resp_count < outstanding);

    // Downstream handshake: a fragment transfers on output_valid && !stall_in; while stalled,
    // the heads (and hence every output field) are held because nothing pops.
    assign output_valid  = (outstanding != '0) && (resp_count != '0);
    assign out_pop       = output_valid && !stall_in;
    assign addr_out      = output_valid ? meta_head.addr  : '0;
    assign color_out     = output_valid ? meta_head.color : '0;
    assign new_depth_out = output_valid ? meta_head.depth : '0;
    assign done_out      = output_valid ? meta_head.done  : 1'b0;
    assign old_depth_out = output_valid ? resp_mem[resp_rd[OUT_LOG2-1:0]] : '0;

    assign outstanding_next = outstanding + {{OUT_LOG2{1'b0}}, accept} - {{OUT_LOG2{1'b0}}, out_pop};

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_empty && (outstanding_next < OUT_FULL)) begin
                    load       = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (accept) begin
                    if (!in_empty && (outstanding_next < OUT_FULL)) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            in_wr          <= '0;
            in_rd          <= '0;
            meta_wr        <= '0;
            meta_rd        <= '0;
            resp_wr        <= '0;
            resp_rd        <= '0;
            stall_out      <= 1'b0;
            master_address <= '0;
            issue          <= '0;
        end else begin
            state     <= state_next;
            stall_out <= (in_count_next >= IN_HIGH);
            if (in_push)   in_wr   <= in_wr + IN_ONE;
            if (in_pop)    in_rd   <= in_rd + IN_ONE;
            if (accept)    meta_wr <= meta_wr + OUT_ONE;
            if (out_pop)   meta_rd <= meta_rd + OUT_ONE;
            if (resp_push) resp_wr <= resp_wr + OUT_ONE;
            if (out_pop)   resp_rd <= resp_rd + OUT_ONE;
            if (load) begin
                issue          <= in_head;
                master_address <= in_head.addr + OFFSET;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (in_push)   in_mem[in_wr[IN_LOG2-1:0]]       <= frag_in;
        if (accept)    meta_mem[meta_wr[OUT_LOG2-1:0]]  <= issue;
        if (resp_push) resp_mem[resp_wr[OUT_LOG2-1:0]]  <= master_readdata;
    end

endmodule

// File: tb/tb_zfetch.sv
// Directed bench for zfetch: table of single-fragment vectors plus hand-written
// sequences for waitrequest, credit limit, backpressure and mid-operation reset.
module tb_zfetch;
  localparam int W = 123;

  logic        clock;
  logic        reset;
  logic        input_valid;
  logic [25:0] addr_in;
  logic [31:0] color_in;
  logic [31:0] new_depth_in;
  logic        done_in;
  logic        stall_out;
  logic        output_valid;
  logic [25:0] addr_out;
  logic [31:0] color_out;
  logic [31:0] new_depth_out;
  logic [31:0] old_depth_out;
  logic        done_out;
  logic        stall_in;
  logic [25:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;
  logic        debug_state;

  zfetch dut (
    .clock(clock), .reset(reset), .input_valid(input_valid), .addr_in(addr_in),
    .color_in(color_in), .new_depth_in(new_depth_in), .done_in(done_in),
    .stall_out(stall_out), .output_valid(output_valid), .addr_out(addr_out),
    .color_out(color_out), .new_depth_out(new_depth_out), .old_depth_out(old_depth_out),
    .done_out(done_out), .stall_in(stall_in), .master_address(master_address),
    .master_read(master_read), .master_write(master_write),
    .master_byteenable(master_byteenable), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest),
    .debug_state(debug_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;
  int out_count = 0;
  int accept_count = 0;
  int mem_lat = 3;
  bit mem_hold = 0;
  bit toggle_stall = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0] mem_aa [logic [25:0]];

  typedef struct {
    logic [25:0] a;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    if (mem_aa.exists(a)) return mem_aa[a];
    return 32'hC0DE_0000 ^ {6'b0, a};
  endfunction

  // memory model: records accepted reads, returns data in order after mem_lat cycles
  initial begin
    pend_t pe;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    forever begin
      @(negedge clock);
      if (master_read && !master_waitrequest) begin
        pend_q.push_back('{a: master_address, due: cyc + mem_lat});
        accept_count++;
      end
      master_readdatavalid = 1'b0;
      master_readdata = '0;
      if (!mem_hold && pend_q.size() != 0 && cyc >= pend_q[0].due) begin
        pe = pend_q.pop_front();
        master_readdatavalid = 1'b1;
        master_readdata = mem_word(pe.a);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock: scoreboard compares the transfer about to happen, then steps past the edge
  task automatic tick();
    logic [W-1:0] act, e;
    @(negedge clock);
    if (reset && output_valid && !stall_in) begin
      n_checks++;
      out_count++;
      act = {addr_out, color_out, new_depth_out, old_depth_out, done_out};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL sb_fragment: got %h expected %h", act, e);
        end
      end
    end
    @(posedge clock);
    #1;
    if (toggle_stall) stall_in = ~stall_in;
  endtask

  task automatic push(input logic [25:0] a, input logic [31:0] c, input logic [31:0] d,
                      input logic dn);
    int k = 0;
    while (stall_out && k < 200) begin
      tick();
      k++;
    end
    input_valid = 1'b1;
    addr_in = a;
    color_in = c;
    new_depth_in = d;
    done_in = dn;
    exp_q.push_back({a, c, d, mem_word(a + 26'd4), dn});
    tick();
    input_valid = 1'b0;
    done_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || master_read || output_valid) && k < 1000) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [25:0] addr;
    logic [31:0] color;
    logic [31:0] nd;
    logic        done;
    logic [25:0] exp_maddr;
    logic [31:0] exp_old;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base;
    int obase;
    bit seen;
    bit early;
    bit bad;

    vecs[0] = '{addr: 26'h0000100, color: 32'h1111_1111, nd: 32'd5, done: 1'b0,
                exp_maddr: 26'h0000104, exp_old: 32'd9};
    vecs[1] = '{addr: 26'h3FFFFFC, color: 32'h2222_2222, nd: 32'd7, done: 1'b1,
                exp_maddr: 26'h0000000, exp_old: 32'h0000_0077};
    vecs[2] = '{addr: 26'h0002000, color: 32'h3333_3333, nd: 32'hFFFF_FFFF, done: 1'b0,
                exp_maddr: 26'h0002004, exp_old: 32'hDEAD_BEEF};
    vecs[3] = '{addr: 26'h1FFFFFC, color: 32'h4444_4444, nd: 32'h0000_0000, done: 1'b0,
                exp_maddr: 26'h2000000, exp_old: 32'h1234_5678};
    mem_aa[26'h0000104] = 32'd9;
    mem_aa[26'h0000000] = 32'h0000_0077;
    mem_aa[26'h0002004] = 32'hDEAD_BEEF;
    mem_aa[26'h2000000] = 32'h1234_5678;

    reset = 1'b0;
    input_valid = 1'b0;
    addr_in = '0;
    color_in = '0;
    new_depth_in = '0;
    done_in = 1'b0;
    stall_in = 1'b0;
    master_waitrequest = 1'b0;
    repeat (3) tick();

    check("rst_output_valid", 64'(output_valid), 64'd0);
    check("rst_master_read", 64'(master_read), 64'd0);
    check("rst_master_address", 64'(master_address), 64'd0);
    check("rst_done_out", 64'(done_out), 64'd0);
    check("rst_stall_out", 64'(stall_out), 64'd0);
    check("rst_state", 64'(debug_state), 64'd0);
    check("tie_master_write", 64'(master_write), 64'd0);
    check("tie_byteenable", 64'(master_byteenable), 64'hF);
    reset = 1'b1;
    tick();
    tick();

    // single fragments: issue latency, address offset/wrap, one-cycle read, output latency
    mem_lat = 3;
    for (int i = 0; i < 4; i++) begin
      base = accept_count;
      push(vecs[i].addr, vecs[i].color, vecs[i].nd, vecs[i].done);
      check("single_read_c0", 64'(master_read), 64'd0);
      tick();
      check("single_read_c1", 64'(master_read), 64'd1);
      check("single_maddr", 64'(master_address), 64'(vecs[i].exp_maddr));
      tick();
      check("single_read_c2", 64'(master_read), 64'd0);
      seen = 1'b0;
      early = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (master_readdatavalid) begin
          seen = 1'b1;
          break;
        end
        if (output_valid) early = 1'b1;
      end
      check("single_rdv_seen", 64'(seen), 64'd1);
      check("single_valid_latency", 64'({early, output_valid}), 64'd1);
      check("single_old_depth", 64'(old_depth_out), 64'(vecs[i].exp_old));
      check("single_done", 64'(done_out), 64'(vecs[i].done));
      tick();
      check("single_valid_gone", 64'(output_valid), 64'd0);
      check("single_accepts", 64'(accept_count - base), 64'd1);
    end

    // waitrequest: request held stable, exactly one acceptance
    mem_lat = 2;
    base = accept_count;
    master_waitrequest = 1'b1;
    push(26'h0000400, 32'hAAAA_0001, 32'd11, 1'b0);
    tick();
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!master_read || master_address !== 26'h0000404) bad = 1'b1;
      tick();
    end
    check("wait_held_stable", 64'(bad), 64'd0);
    check("wait_no_accept", 64'(accept_count - base), 64'd0);
    master_waitrequest = 1'b0;
    check("wait_read_still", 64'(master_read), 64'd1);
    tick();
    check("wait_read_drop", 64'(master_read), 64'd0);
    wait_drain("wait_drain");
    check("wait_one_accept", 64'(accept_count - base), 64'd1);

    // credit limit: 8 reads outstanding max, stall_out at input count 6
    mem_lat = 1;
    mem_hold = 1'b1;
    stall_in = 1'b1;
    base = accept_count;
    obase = out_count;
    for (int i = 0; i < 12; i++) push(26'h0001000 + 26'(i * 16), 32'hBB00_0000 + 32'(i), 32'(i), 1'b0);
    repeat (5) tick();
    check("credit_accepts", 64'(accept_count - base), 64'd8);
    check("credit_read_idle", 64'(master_read), 64'd0);
    check("credit_stall_at4", 64'(stall_out), 64'd0);
    push(26'h0001100, 32'hBB00_000C, 32'd12, 1'b0);
    check("credit_stall_at5", 64'(stall_out), 64'd0);
    push(26'h0001110, 32'hBB00_000D, 32'd13, 1'b1);
    check("credit_stall_at6", 64'(stall_out), 64'd1);
    check("credit_still_8", 64'(accept_count - base), 64'd8);
    stall_in = 1'b0;
    mem_hold = 1'b0;
    wait_drain("credit_drain");
    check("credit_all_accepted", 64'(accept_count - base), 64'd14);
    check("credit_all_out", 64'(out_count - obase), 64'd14);
    check("credit_stall_clear", 64'(stall_out), 64'd0);

    // backpressure: stall_in toggles every cycle
    obase = out_count;
    toggle_stall = 1'b1;
    for (int i = 0; i < 20; i++) push(26'(i * 4), 32'hCC00_0000 | 32'(i), 32'(1000 + i), 1'b0);
    wait_drain("bp_drain");
    toggle_stall = 1'b0;
    stall_in = 1'b0;
    check("bp_count", 64'(out_count - obase), 64'd20);

    // reset with three reads outstanding
    mem_hold = 1'b1;
    mem_lat = 1;
    base = accept_count;
    push(26'h0008000, 32'hDD00_0000, 32'd1, 1'b1);
    push(26'h0008010, 32'hDD00_0001, 32'd2, 1'b0);
    push(26'h0008020, 32'hDD00_0002, 32'd3, 1'b0);
    repeat (4) tick();
    check("mid_accepts", 64'(accept_count - base), 64'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(output_valid), 64'd0);
    check("mid_rst_read", 64'(master_read), 64'd0);
    check("mid_rst_maddr", 64'(master_address), 64'd0);
    check("mid_rst_done", 64'(done_out), 64'd0);
    check("mid_rst_stall", 64'(stall_out), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    mem_hold = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (output_valid) bad = 1'b1;
    end
    check("stale_discarded", 64'(bad), 64'd0);
    check("stale_drained", 64'(pend_q.size()), 64'd0);
    obase = out_count;
    push(26'h0008800, 32'hEE00_0000, 32'd42, 1'b1);
    wait_drain("fresh_drain");
    check("fresh_out", 64'(out_count - obase), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zfetch.md
Name: zfetch

Overview:
- Depth-read stage placed directly in front of the z-test/write-back stage.
- Accepts rasterized fragments and reads the stored depth word for each pixel from the framebuffer over an Avalon-MM read master.
- Emits each fragment, paired with its stored (old) depth, in order to the z-test stage.
- Multiple reads can be in flight; a credit scheme keeps the response buffer from overflowing.

Parameters:
- IN_LOG2, 3, log2 of input fragment FIFO depth (8 entries).
- OUT_LOG2, 3, log2 of max outstanding reads and the response/metadata buffer depth (8).
- DEPTH_OFFSET, 4, byte offset from a pixel's color word to its depth word.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- input_valid  in  1  fragment present on the *_in buses
- addr_in  in  26  byte address of the pixel color word
- color_in  in  32  fragment color
- new_depth_in  in  32  fragment depth
- done_in  in  1  end-of-frame marker carried with the fragment
- stall_out  out  1  upstream must stop presenting fragments
- output_valid  out  1  fragment plus old depth available
- addr_out  out  26  pixel color address
- color_out  out  32  fragment color
- new_depth_out  out  32  fragment depth
- old_depth_out  out  32  depth read from memory
- done_out  out  1  done marker of the presented fragment
- stall_in  in  1  downstream cannot accept
- master_address  out  26  read address
- master_read  out  1  read request
- master_write  out  1  tied 0
- master_byteenable  out  4  tied 4'b1111
- master_readdata  in  32  read data
- master_readdatavalid  in  1  read data valid
- master_waitrequest  in  1  slave stall

Behaviour:
- Reset (reset=0, async):
  - All FIFOs empty; outstanding count 0.
  - master_read=0, master_address=0, output_valid=0, done_out=0, stall_out=0.
  - Any in-flight reads are abandoned. Readdatavalid pulses arriving after reset release are discarded while outstanding count is 0.
- Input:
  - Fragment {addr, color, new_depth, done} is written to the input FIFO on every cycle with input_valid=1 and FIFO not full.
  - stall_out is registered and equals (input count >= 2^IN_LOG2 - 2), giving two cycles of upstream slack.
  - input_valid while full is a protocol violation; the write is ignored.
- Read issue, states S_IDLE / S_REQ:
  - S_IDLE → S_REQ when the input FIFO is non-empty and outstanding < 2^OUT_LOG2.
  - On that transition, pop the input FIFO head into the issue register. Drive master_address = head.addr + DEPTH_OFFSET (26-bit wrap) and master_read=1.
  - In S_REQ, master_address and master_read are held stable while master_waitrequest=1.
  - On master_waitrequest=0 the read is accepted: push the issue register into the metadata FIFO and increment outstanding.
  - After acceptance: if the next fragment and a credit are available, reload immediately and stay in S_REQ (back-to-back, one read per cycle). Otherwise deassert master_read and return to S_IDLE.
- Response:
  - Every master_readdatavalid=1 pushes master_readdata into the response FIFO.
  - Responses are in order. Credits guarantee no overflow.
- Output:
  - output_valid = metadata FIFO non-empty AND response FIFO non-empty.
  - Output fields come from the metadata head and the response head.
  - Pop both heads on output_valid && !stall_in; outstanding decrements on that pop.
  - Same-cycle increment and decrement leave outstanding unchanged.
  - Fields are stable while output_valid=1 and stall_in=1.
- Latency:
  - Accept at cycle 0 → master_read asserted at cycle 1 (input FIFO empty, no waitrequest).
  - readdatavalid at cycle N → output_valid at cycle N+1.
- done_in propagates unchanged with its fragment. No fragment is dropped or reordered.

Test Plan:
- Single fragment, no waitrequest:
  - Stimulus: addr_in=0x100, new_depth=5, readdata=9 after 3 cycles.
  - Required: master_address=0x104 at cycle 1, one cycle of master_read.
  - Required: output addr 0x100, new 5, old 9, valid one cycle after readdatavalid.
- Waitrequest:
  - Stimulus: hold master_waitrequest=1 for 4 cycles.
  - Required: master_address/master_read unchanged for all 4 cycles; exactly one read accepted.
- Credit limit:
  - Stimulus: 12 back-to-back fragments, stall_in=1, memory never returns data.
  - Required: exactly 8 reads accepted, then master_read=0; stall_out asserts once input count reaches 6.
  - Then release data and stall_in: all 12 delivered in order.
- Backpressure:
  - Stimulus: toggle stall_in every cycle, 20 fragments with addresses 0..76 step 4.
  - Required: outputs in order, none duplicated, old depths match the memory model.
- Wrap and done:
  - Stimulus: addr_in=0x3FFFFFC with done_in=1.
  - Required: master_address=0x0000000; done_out=1 only on that fragment.
- Reset mid-operation:
  - Stimulus: assert reset with 3 reads outstanding.
  - Required: all outputs immediately 0; stale readdatavalid ignored.
  - Required: a fresh fragment then completes normally.
